// File: rtl/iter_div_fsm.sv
// rtl/iter_div_fsm.sv - control FSM of an iterative restoring divider; optional FSM_STATE_DBG_EN exposes state_dbg
module iter_div_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       E,
    input  logic       cout,
    input  logic       zC,
    output logic       LAB,
    output logic       EA,
    output logic       EC,
    output logic       sclrC,
    output logic       sclrR,
    output logic       LR,
    output logic       ER,
`ifdef FSM_STATE_DBG_EN
    output logic [1:0] state_dbg,
`endif
    output logic       done
);

    typedef enum logic [1:0] {
        S1    = 2'b00,
        S2    = 2'b01,
        S3    = 2'b10,
        S_ILL = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S1;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy outputs: S1 loads operands the same cycle E rises, S2 picks LR from cout.
    always_comb begin
        state_d = S1;
        LAB     = 1'b0;
        EA      = 1'b0;
        EC      = 1'b0;
        sclrC   = 1'b0;
        sclrR   = 1'b0;
        LR      = 1'b0;
        ER      = 1'b0;
        done    = 1'b0;
        case (state_q)
            S1: begin
                ER      = 1'b1;
                sclrR   = 1'b1;
                EC      = 1'b1;
                sclrC   = 1'b1;
                LAB     = E;
                EA      = E;
                state_d = E ? S2 : S1;
            end
            S2: begin
                ER      = 1'b1;
                EA      = 1'b1;
                EC      = 1'b1;
                LR      = cout;
                state_d = zC ? S3 : S2;
            end
            S3: begin
                done    = 1'b1;
                state_d = E ? S3 : S1;
            end
            default: begin
                state_d = S1;
            end
        endcase
    end

`ifdef FSM_STATE_DBG_EN
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (state_q != S_ILL)
                else $error("iter_div_fsm: illegal state 2'b11");
        end
    end
`endif

endmodule

// File: tb/tb_iter_div_fsm.sv
// tb/tb_iter_div_fsm.sv - directed vector bench for iter_div_fsm
module tb_iter_div_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic E = 1'b0;
    logic cout = 1'b0;
    logic zC = 1'b0;
    logic LAB, EA, EC, sclrC, sclrR, LR, ER, done;
`ifdef FSM_STATE_DBG_EN
    logic [1:0] state_dbg;
`endif

    always #5 clk = ~clk;

    iter_div_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .E         (E),
        .cout      (cout),
        .zC        (zC),
        .LAB       (LAB),
        .EA        (EA),
        .EC        (EC),
        .sclrC     (sclrC),
        .sclrR     (sclrR),
        .LR        (LR),
        .ER        (ER),
`ifdef FSM_STATE_DBG_EN
        .state_dbg (state_dbg),
`endif
        .done      (done)
    );

    // Expected output byte order: {LAB, EA, EC, sclrC, sclrR, LR, ER, done}
    localparam logic [7:0] O_IDLE   = 8'h3A;
    localparam logic [7:0] O_START  = 8'hFA;
    localparam logic [7:0] O_ITER0  = 8'h62;
    localparam logic [7:0] O_ITER1  = 8'h66;
    localparam logic [7:0] O_DONE   = 8'h01;

    typedef struct {
        logic       rst;
        logic       e;
        logic       c;
        logic       z;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [7:0] outs();
        return {LAB, EA, EC, sclrC, sclrR, LR, ER, done};
    endfunction

    function automatic void add(logic rst, logic e, logic c, logic z, logic chk, logic [7:0] exp);
        vec_t v;
        v.rst = rst; v.e = e; v.c = c; v.z = z; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int cnt;
        bit got_done;

        // Reset held 10 cycles; first cycle state is unknown so it is not checked.
        add(1, 0, 0, 0, 0, O_IDLE);
        for (int i = 0; i < 9; i++) add(1, 0, 0, 0, 1, O_IDLE);
        add(0, 0, 1, 1, 1, O_IDLE);           // idle ignores cout/zC
        add(0, 1, 0, 0, 1, O_START);          // S1 -> S2
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 1, O_ITER0);
        add(0, 1, 1, 0, 1, O_ITER1);          // LR follows cout, stay S2
        add(0, 1, 1, 1, 1, O_ITER1);          // cout and zC together -> S3
        for (int i = 0; i < 6; i++) add(0, 1, 1, 1, 1, O_DONE);
        add(0, 0, 0, 0, 1, O_DONE);           // release E -> S1
        add(0, 0, 0, 0, 1, O_IDLE);
        add(0, 1, 0, 0, 1, O_START);
        add(0, 1, 0, 0, 1, O_ITER0);
        add(1, 1, 0, 0, 1, O_ITER0);          // reset in S2 -> S1
        add(0, 0, 0, 0, 1, O_IDLE);           // no done pulse
        add(0, 1, 0, 0, 1, O_START);
        add(0, 0, 0, 1, 1, O_ITER0);          // E ignored in S2; zC -> S3
        add(0, 0, 0, 0, 1, O_DONE);           // -> S1
        add(0, 1, 0, 0, 1, O_START);
        add(0, 1, 0, 1, 1, O_ITER0);          // -> S3
        add(1, 1, 0, 0, 1, O_DONE);           // reset overrides S3 hold
        add(0, 0, 0, 0, 1, O_IDLE);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            E     = vecs[i].e;
            cout  = vecs[i].c;
            zC    = vecs[i].z;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Eight-iteration division driven by a bench-side counter model.
        @(negedge clk);
        reset = 0; E = 1; cout = 0; zC = 0;
        #1 check("run_start", outs(), O_START);
        cnt = 0;
        got_done = 0;
        for (int k = 0; k < 50 && !got_done; k++) begin
            @(negedge clk);
            zC   = (cnt == 7);
            cout = 1'($urandom_range(0, 1));
            #1;
            if (done) begin
                got_done = 1;
            end else begin
                check($sformatf("run_iter%0d", cnt), outs(), cout ? O_ITER1 : O_ITER0);
                cnt++;
            end
        end
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL run_timeout: done not seen, iterations=%0d required=8", cnt);
        end else if (cnt != 8) begin
            failures++;
            $display("FAIL run_count: iterations=%0d required=8", cnt);
        end

        // E held high must not retrigger.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cout = 1; zC = 0;
            #1 check($sformatf("hold%0d", k), outs(), O_DONE);
        end
        @(negedge clk);
        E = 0;
        @(negedge clk);
        #1 check("rearm_idle", outs(), O_IDLE);

`ifdef FSM_STATE_DBG_EN
        check("dbg_idle", {6'd0, state_dbg}, 8'h00);
        @(negedge clk);
        reset = 1;
        force dut.state_q = dut.S_ILL;
        #1 check("illegal_outs", outs(), 8'h00);
        release dut.state_q;
        @(negedge clk);
        reset = 0;
        #1 check("illegal_recover", {6'd0, state_dbg}, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
